// File: rtl/if_prefetch.sv
// if_prefetch: fetch PC owner, ROM driver and small {pc,inst} queue feeding IF/ID.
// Ports: clk, rst (async active-low), rom_addr_o/rom_ce_o/rom_data_i (ROM side),
//   redirect_i/redirect_pc_i (flush + restart), inst_valid_o/inst_ready_i/inst_o/pc_o
//   (consumer handshake), flush_cnt_o (discarded entries, only with IF_FLUSH_CNT_EN).
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    input  logic [31:0] rom_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [15:0] flush_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] inst_mem_q [DEPTH];

    logic empty;
    logic pop;
    logic push;

    assign empty        = (count_q == '0);
    assign inst_valid_o = !empty && !redirect_i;
    assign pop          = inst_valid_o && inst_ready_i;
    // A pop frees a slot this cycle, so a full queue can still fetch.
    assign rom_ce_o     = rst && !redirect_i && ((count_q < FULL) || pop);
    assign push         = rom_ce_o;
    assign rom_addr_o   = fetch_pc_q;
    assign inst_o       = empty ? 32'h0 : inst_mem_q[head_q];
    assign pc_o         = empty ? 32'h0 : pc_mem_q[head_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~32'h3;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tail_d     = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]   <= fetch_pc_q;
            inst_mem_q[tail_q] <= rom_data_i;
        end
    end

`ifdef IF_FLUSH_CNT_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [16:0] flush_sum;

    assign flush_sum = {1'b0, flush_cnt_q} + 17'(count_q);

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (redirect_i) begin
            flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt_q <= 16'h0000;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_cnt_o = flush_cnt_q;
`else
    assign flush_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, stall/fill, redirect, wrap, async reset.
module tb_if_prefetch;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;
`ifdef IF_FLUSH_CNT_EN
    localparam logic [15:0] FL3 = 16'd3;
`else
    localparam logic [15:0] FL3 = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic        rom_ce;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [15:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_addr ^ PAT;

    if_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr_o    (rom_addr),
        .rom_ce_o      (rom_ce),
        .rom_data_i    (rom_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inst_valid_o  (inst_valid),
        .inst_ready_i  (inst_ready),
        .inst_o        (inst),
        .pc_o          (pc),
        .flush_cnt_o   (flush_cnt)
    );

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst         = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        chk1 ("rst_ce", rom_ce, 1'b0);
        chk32("rst_addr", rom_addr, 32'h0);
        chk1 ("rst_valid", inst_valid, 1'b0);
        chk32("rst_inst", inst, 32'h0);
        chk32("rst_pc", pc, 32'h0);
        chk32("rst_flush", {16'h0, flush_cnt}, 32'h0);

        tick();
        tick();
        inst_ready = 1'b1;
        rst        = 1'b1;
        #1;
        chk1 ("rel_ce", rom_ce, 1'b1);
        chk1 ("rel_valid", inst_valid, 1'b0);
        chk32("rel_addr", rom_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk1 ("str_valid", inst_valid, 1'b1);
            chk32("str_pc", pc, 32'(4 * i));
            chk32("str_inst", inst, 32'(4 * i) ^ PAT);
        end

        #1;
        rst = 1'b0;
        #1;
        chk1 ("arst_ce", rom_ce, 1'b0);
        chk1 ("arst_valid", inst_valid, 1'b0);
        chk32("arst_pc", pc, 32'h0);
        chk32("arst_addr", rom_addr, 32'h0);
        inst_ready = 1'b0;
        rst        = 1'b1;
        #1;
        chk1 ("fill0_ce", rom_ce, 1'b1);
        chk1 ("fill0_valid", inst_valid, 1'b0);
        tick();
        #1;
        chk1 ("fill1_valid", inst_valid, 1'b1);
        chk32("fill1_pc", pc, 32'h0);
        chk32("fill1_addr", rom_addr, 32'h4);
        tick();
        tick();
        tick();
        #1;
        chk1 ("full_ce", rom_ce, 1'b0);
        chk32("full_addr", rom_addr, 32'h10);
        chk32("full_pc", pc, 32'h0);
        chk32("full_inst", inst, PAT);
        tick();
        #1;
        chk1 ("hold_ce", rom_ce, 1'b0);
        chk32("hold_addr", rom_addr, 32'h10);
        chk32("hold_pc", pc, 32'h0);
        inst_ready = 1'b1;
        #1;
        chk1 ("pop_ce", rom_ce, 1'b1);
        chk32("pop_pc", pc, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            #1;
            chk1 ("drain_valid", inst_valid, 1'b1);
            chk32("drain_pc", pc, 32'(4 * i));
        end

        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk1("rdf_valid", inst_valid, 1'b0);
        chk1("rdf_ce", rom_ce, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chk1 ("rdf1_valid", inst_valid, 1'b0);
        chk1 ("rdf1_ce", rom_ce, 1'b1);
        chk32("rdf1_addr", rom_addr, 32'h200);
        chk32("rdf1_pc", pc, 32'h0);
        tick();
        #1;
        chk1 ("rdf2_valid", inst_valid, 1'b1);
        chk32("rdf2_pc", pc, 32'h200);

        redirect    = 1'b1;
        redirect_pc = 32'h300;
        #1;
        chk1("rdh_valid", inst_valid, 1'b0);
        tick();
        redirect_pc = 32'h404;
        tick();
        redirect_pc = 32'h503;
        #1;
        chk1("rdh_valid3", inst_valid, 1'b0);
        chk1("rdh_ce3", rom_ce, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chk32("rdh_addr", rom_addr, 32'h500);
        chk1 ("rdh_valid4", inst_valid, 1'b0);
        tick();
        #1;
        chk1 ("rdh_valid5", inst_valid, 1'b1);
        chk32("rdh_pc", pc, 32'h500);
        chk32("rdh_inst", inst, 32'h500 ^ PAT);

        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        #1;
        chk32("wrap_pc0", pc, 32'hFFFF_FFFC);
        tick();
        #1;
        chk32("wrap_pc1", pc, 32'h0);
        chk32("wrap_inst1", inst, PAT);

        #1;
        rst = 1'b0;
        #1;
        chk32("arst2_flush", {16'h0, flush_cnt}, 32'h0);
        inst_ready = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        tick();
        #1;
        chk1 ("q3_valid", inst_valid, 1'b1);
        chk32("q3_pc", pc, 32'h0);
        chk32("q3_addr", rom_addr, 32'hC);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk1("q3r_valid", inst_valid, 1'b0);
        chk1("q3r_ce", rom_ce, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chk1 ("q3r1_valid", inst_valid, 1'b0);
        chk32("q3r1_addr", rom_addr, 32'h100);
        chk32("q3r1_flush", {16'h0, flush_cnt}, {16'h0, FL3});
        tick();
        #1;
        chk1 ("q3r2_valid", inst_valid, 1'b1);
        chk32("q3r2_pc", pc, 32'h100);
        inst_ready = 1'b1;
        tick();
        #1;
        chk32("q3r3_pc", pc, 32'h104);
        chk32("q3r3_inst", inst, 32'h104 ^ PAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction-fetch prefetch unit between the CPU's decode stage and the instruction ROM. It owns the fetch PC, drives the ROM address/enable, and captures returned words into a small queue. It presents fetched instructions to the IF/ID register over a valid/ready handshake. A single-cycle redirect (branch/jump) flushes the queue and restarts fetching at a new PC.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rom_addr_o`  out  32  ROM word address (byte address, bits [1:0] always 0).
- `rom_ce_o`  out  1  ROM chip enable; 1 = fetch this cycle.
- `rom_data_i`  in  32  ROM read data; combinational response to `rom_addr_o` in the same cycle.
- `redirect_i`  in  1  flush queue and restart fetch.
- `redirect_pc_i`  in  32  new fetch PC; sampled when `redirect_i`=1.
- `inst_valid_o`  out  1  head entry valid.
- `inst_ready_i`  in  1  consumer accepts head this cycle.
- `inst_o`  out  32  head instruction word.
- `pc_o`  out  32  PC of head instruction.
- `flush_cnt_o`  out  16  discarded-entry counter (only with `IF_FLUSH_CNT_EN`).

## Operation
- State: `fetch_pc` (32b), circular queue of {pc, inst}, head/tail pointers, occupancy `count` (0..DEPTH).
- Reset (rst=0, async): `fetch_pc`=RESET_PC, `count`=0, pointers 0, `flush_cnt`=0. Outputs during reset: `rom_ce_o`=0, `rom_addr_o`=RESET_PC, `inst_valid_o`=0, `inst_o`=0, `pc_o`=0.
- `pop` = `inst_valid_o` & `inst_ready_i`.
- `rom_ce_o` = rst & !`redirect_i` & (`count`<DEPTH | `pop`). `rom_addr_o` = `fetch_pc` at all times.
- Push: when `rom_ce_o`=1, push {`fetch_pc`, `rom_data_i`} at the clock edge. `fetch_pc` += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Pop: advance head. Push and pop in the same cycle leaves `count` unchanged. This includes the full case, where the pop frees the slot the push fills.
- `inst_valid_o` = (`count`!=0) & !`redirect_i`. `inst_o`/`pc_o` show the head entry and are held stable while valid & !ready. They are 0 when `count`=0.
- Redirect has priority over push and pop. At the edge: queue emptied (`count`=0), no push, no pop, `fetch_pc` = {`redirect_pc_i`[31:2], 2'b00}. The consumer never sees an accepted instruction in a redirect cycle.
- Back-to-back redirects: the last one wins. Fetching resumes in the first cycle with `redirect_i`=0.

## Timing
- Fetch-to-output latency: 1 cycle. A word fetched in cycle N is visible on `inst_o` in cycle N+1.
- After reset release: first edge pushes RESET_PC. `inst_valid_o`=1 from the following cycle.
- Sustained throughput with `inst_ready_i`=1: 1 instruction/cycle, no bubbles.
- Redirect in cycle N: `inst_valid_o`=0 in N and N+1. Target instruction is valid in N+2.
- Full queue with `inst_ready_i`=0: `rom_ce_o`=0 and `fetch_pc` is held. Raising ready restarts fetch in the same cycle (`pop` path).

## Configuration
- `IF_FLUSH_CNT_EN` defined:
  - `flush_cnt_o` is a 16-bit counter incremented by `count` on every redirect edge.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: no counter register; `flush_cnt_o` is tied to 16'h0000.
- Fetch/handshake behaviour is identical in both builds.

## Test plan
- Reset then ready=1, ROM returns data=addr^32'hA5A5_A5A5 -> `inst_valid_o` rises the 2nd cycle after rst release; `pc_o` = 0,4,8,C… one per cycle; `inst_o` matches the pattern.
- ready=0 from reset -> after 4 edges `count`=4, `rom_ce_o`=0, `rom_addr_o`=0x10. Then ready=1 -> `pc_o` 0,4,8,C,0x10 on consecutive cycles with no gap.
- 3 entries queued, `redirect_i`=1 with `redirect_pc_i`=0x100 for one cycle -> `inst_valid_o`=0 for 2 cycles, then `pc_o`=0x100, 0x104. `flush_cnt_o`=3 with the macro, 0 without.
- Redirect to 0x103 -> next fetch address 0x100. Redirect to 0xFFFF_FFFC -> `pc_o` 0xFFFF_FFFC then 0x0000_0000.
- Redirect asserted while full and ready=1 -> no entry is accepted that cycle and the queue ends empty. Redirect held 3 cycles with changing PCs -> fetch starts at the last PC.
- Async rst asserted mid-stream between clock edges -> `rom_ce_o`=0 and `inst_valid_o`=0 immediately. After release, fetch restarts at RESET_PC.
